// File: rtl/bus_access_pkg.sv
// Shared types and helpers for the bus access sequencer.
package bus_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Lanes touched by an n-byte access at offset off, over two bus words:
  // low BUS_BYTES bits are the first word, the next BUS_BYTES the second.
  function automatic logic [15:0] lane_mask(input logic [3:0] off, input logic [3:0] n);
    logic [15:0] ones;
    ones = (16'd1 << n) - 16'd1;
    return ones << off;
  endfunction

endpackage

// File: rtl/bus_access_unit_byte_rotator.sv
// Byte-granular barrel rotator; LEFT=1 rotates towards higher lanes.
module byte_rotator #(
  parameter int BUS_BYTES = 2,
  parameter bit LEFT      = 1'b1,
  localparam int DW = 8 * BUS_BYTES,
  localparam int OW = $clog2(BUS_BYTES)
) (
  input  logic [DW-1:0] data_i,
  input  logic [OW-1:0] amt_i,
  output logic [DW-1:0] data_o
);

  logic [OW-1:0] src;

  always_comb begin
    data_o = '0;
    src    = '0;
    for (int b = 0; b < BUS_BYTES; b++) begin
      src = LEFT ? (OW'(b) - amt_i) : (OW'(b) + amt_i);
      data_o[8*b +: 8] = data_i[8*src +: 8];
    end
  end

endmodule

// File: rtl/bus_access_unit.sv
// Load/store sequencer: splits unaligned accesses into up to two bus
// transactions, merges read lanes and extends the load result.
module bus_access_unit
  import bus_access_pkg::*;
#(
  parameter int BUS_BYTES = 2,
  parameter int ADDR_W    = 16,
  parameter int SIZE_W    = 2,
  localparam int DW = 8 * BUS_BYTES,
  localparam int OW = $clog2(BUS_BYTES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [SIZE_W-1:0]    req_size,
  input  logic                 req_signed,
  input  logic [DW-1:0]        req_wdata,
  output logic                 resp_valid,
  output logic [DW-1:0]        resp_rdata,
  output logic                 bus_valid,
  output logic                 bus_write,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [BUS_BYTES-1:0] bus_be,
  output logic [DW-1:0]        bus_wdata,
  input  logic                 bus_ready,
  input  logic [DW-1:0]        bus_rdata
);

  localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(OW);

  state_e              state_q, state_d;
  logic                write_q, signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          n_q;
  logic [DW-1:0]       wdata_q, merge_q, merge_d;

  logic                  accept;
  logic [SIZE_W-1:0]     eff_sz;
  logic [3:0]            n_acc;
  logic [OW-1:0]         off;
  logic [2*BUS_BYTES-1:0] lanes;
  logic [BUS_BYTES-1:0]  be_first, be_second, cap_be;
  logic                  split;
  logic [ADDR_W-1:0]     aligned;
  logic [DW-1:0]         cap_bits, rot_rd, ext;
  logic                  sgn;

  assign accept = req_valid && (state_q == S_IDLE);
  assign eff_sz = (req_size > MAX_SZ) ? MAX_SZ : req_size;
  assign n_acc  = 4'd1 << eff_sz;

  assign off       = addr_q[OW-1:0];
  assign lanes     = (2*BUS_BYTES)'(lane_mask(4'(off), n_q));
  assign be_first  = lanes[BUS_BYTES-1:0];
  assign be_second = lanes[2*BUS_BYTES-1:BUS_BYTES];
  assign split     = |be_second;
  assign aligned   = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_FIRST;
      S_FIRST:  if (bus_ready) state_d = split ? S_SECOND : S_DONE;
      S_SECOND: if (bus_ready) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_valid = 1'b0;
    bus_be    = '0;
    bus_addr  = aligned;
    case (state_q)
      S_FIRST: begin
        bus_valid = 1'b1;
        bus_be    = be_first;
      end
      S_SECOND: begin
        bus_valid = 1'b1;
        bus_be    = be_second;
        bus_addr  = aligned + ADDR_W'(BUS_BYTES);
      end
      default: ;
    endcase
  end

  assign bus_write  = write_q && bus_valid;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);

  // Read lanes land in bus-lane order; the two words never overlap.
  always_comb begin
    cap_be   = (state_q == S_SECOND) ? be_second : be_first;
    cap_bits = '0;
    for (int b = 0; b < BUS_BYTES; b++) cap_bits[8*b +: 8] = {8{cap_be[b]}};
    merge_d = merge_q;
    if (accept)
      merge_d = '0;
    else if (bus_valid && bus_ready && !write_q)
      merge_d = (merge_q & ~cap_bits) | (bus_rdata & cap_bits);
  end

  byte_rotator #(.BUS_BYTES(BUS_BYTES), .LEFT(1'b1)) u_st_rot (
    .data_i(wdata_q), .amt_i(off), .data_o(bus_wdata)
  );

  byte_rotator #(.BUS_BYTES(BUS_BYTES), .LEFT(1'b0)) u_ld_rot (
    .data_i(merge_q), .amt_i(off), .data_o(rot_rd)
  );

  always_comb begin
    sgn = 1'b0;
    ext = '0;
    for (int b = 0; b < BUS_BYTES; b++)
      if (b == int'(n_q) - 1) sgn = rot_rd[8*b+7];
    for (int b = 0; b < BUS_BYTES; b++)
      ext[8*b +: 8] = (b < int'(n_q)) ? rot_rd[8*b +: 8] : {8{sgn & signed_q}};
  end

  assign resp_rdata = (state_q == S_DONE && !write_q) ? ext : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      n_q      <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        n_q      <= n_acc;
        wdata_q  <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_access_unit.sv
// Randomized + directed bench: BUS_BYTES=2 and BUS_BYTES=4 instances share stimulus.
module tb_bus_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel, req_valid, req_write, req_signed, bus_ready;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata, bus_rdata;

  logic        rv2, rr2, rsv2, bv2, bw2;
  logic [15:0] rd2, ba2, bwd2;
  logic [1:0]  be2;
  logic        rv4, rr4, rsv4, bv4, bw4;
  logic [31:0] rd4, bwd4;
  logic [15:0] ba4;
  logic [3:0]  be4;

  assign rv2 = req_valid & ~sel;
  assign rv4 = req_valid & sel;

  bus_access_unit #(.BUS_BYTES(2), .ADDR_W(16), .SIZE_W(2)) u2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rr2), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata[15:0]), .resp_valid(rsv2), .resp_rdata(rd2), .bus_valid(bv2),
    .bus_write(bw2), .bus_addr(ba2), .bus_be(be2), .bus_wdata(bwd2),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata[15:0])
  );

  bus_access_unit #(.BUS_BYTES(4), .ADDR_W(16), .SIZE_W(2)) u4 (
    .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rr4), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(rsv4), .resp_rdata(rd4), .bus_valid(bv4),
    .bus_write(bw4), .bus_addr(ba4), .bus_be(be4), .bus_wdata(bwd4),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  logic        o_rr, o_rsv, o_bv, o_bw;
  logic [15:0] o_ba;
  logic [3:0]  o_be;
  logic [31:0] o_bwd, o_rd;
  assign o_rr  = sel ? rr4 : rr2;
  assign o_rsv = sel ? rsv4 : rsv2;
  assign o_bv  = sel ? bv4 : bv2;
  assign o_bw  = sel ? bw4 : bw2;
  assign o_ba  = sel ? ba4 : ba2;
  assign o_be  = sel ? be4 : {2'b00, be2};
  assign o_bwd = sel ? bwd4 : {16'h0, bwd2};
  assign o_rd  = sel ? rd4 : {16'h0, rd2};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed backing store: explicit overrides, else a fixed hash.
  logic [7:0] mem [int];
  function automatic logic [7:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37 + 11) ^ (a >> 5));
  endfunction

  logic [15:0] g_ba [2];
  logic [3:0]  g_be [2];
  logic [31:0] g_wd [2];
  logic [31:0] g_rd;
  int          g_lat;

  // One access end to end; the model enumerates the touched byte addresses
  // and groups them into bus words.
  task automatic run_access(input logic s, input logic w, input logic [15:0] a,
                            input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                            input int mode, input int stall0);
    int bb, n, cnt, cyc, ntx, stall;
    int e_addr [2];
    logic [3:0] e_be [2];
    logic [7:0] e_wb [2][4];
    logic [31:0] exp_rd, got_rd, p_wd;
    logic [15:0] p_ba;
    logic [3:0]  p_be;
    logic p_wait, done, sign;
    bb = s ? 4 : 2;
    n = 1 << sz;
    if (n > bb) n = bb;
    cnt = 0;
    for (int i = 0; i < 2; i++) begin e_addr[i] = -1; e_be[i] = '0; end
    for (int i = 0; i < n; i++) begin
      int ba, wa;
      ba = (int'(a) + i) % 65536;
      wa = ba - (ba % bb);
      if (cnt == 0 || e_addr[cnt-1] != wa) begin e_addr[cnt] = wa; cnt++; end
      e_be[cnt-1][ba % bb] = 1'b1;
      e_wb[cnt-1][ba % bb] = wd[8*i +: 8];
    end
    exp_rd = '0;
    for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = mem_rd((int'(a) + i) % 65536);
    if (sg && n < bb) begin
      sign = exp_rd[8*n-1];
      for (int i = 8*n; i < 8*bb; i++) exp_rd[i] = sign;
    end
    if (w) exp_rd = '0;
    for (int i = 0; i < 2; i++) begin g_ba[i] = '0; g_be[i] = '0; g_wd[i] = '0; end

    sel = s; req_write = w; req_addr = a; req_size = sz; req_signed = sg;
    req_wdata = wd; req_valid = 1'b1; bus_ready = 1'b0;
    #1;
    chk("idle_req_ready", 32'(o_rr), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 16'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
    cyc = 1; ntx = 0; done = 1'b0; p_wait = 1'b0; stall = stall0; got_rd = '0;
    p_ba = '0; p_be = '0; p_wd = '0;
    while (!done && cyc < 60) begin
      if (o_rsv) begin
        done = 1'b1; g_lat = cyc; got_rd = o_rd;
        chk("done_bus_valid", 32'(o_bv), 32'd0);
        chk("done_req_ready", 32'(o_rr), 32'd0);
      end else begin
        chk("busy_req_ready", 32'(o_rr), 32'd0);
        chk("busy_bus_valid", 32'(o_bv), 32'd1);
        if (p_wait) begin
          chk("hold_addr", 32'(o_ba), 32'(p_ba));
          chk("hold_be", 32'(o_be), 32'(p_be));
          chk("hold_wdata", o_bwd, p_wd);
        end
        bus_rdata = '0;
        for (int l = 0; l < bb; l++) bus_rdata[8*l +: 8] = mem_rd(int'(o_ba) + l);
        if (stall > 0) begin bus_ready = 1'b0; stall--; end
        else if (mode == 1) bus_ready = ($urandom_range(0, 9) < 7);
        else bus_ready = 1'b1;
        if (bus_ready) begin
          if (ntx < 2) begin
            chk("tx_addr", 32'(o_ba), 32'(e_addr[ntx]));
            chk("tx_be", 32'(o_be), 32'(e_be[ntx]));
            chk("tx_write", 32'(o_bw), 32'(w));
            if (w)
              for (int l = 0; l < bb; l++)
                if (e_be[ntx][l]) chk("tx_wbyte", 32'(o_bwd[8*l +: 8]), 32'(e_wb[ntx][l]));
            g_ba[ntx] = o_ba; g_be[ntx] = o_be; g_wd[ntx] = o_bwd;
          end
          ntx++;
        end
        p_wait = !bus_ready; p_ba = o_ba; p_be = o_be; p_wd = o_bwd;
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    chk("resp_seen", 32'(done), 32'd1);
    chk("tx_count", 32'(ntx), 32'(cnt));
    chk("resp_rdata", got_rd, exp_rd);
    if (mode == 0 && stall0 == 0) chk("latency", 32'(g_lat), 32'(1 + cnt));
    g_rd = got_rd;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", 32'(o_rsv), 32'd0);
    chk("back_to_idle", 32'(o_rr), 32'd1);
  endtask

  initial begin
    int acc;
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_req_ready", 32'(o_rr), 32'd1);
      chk("rst_resp_valid", 32'(o_rsv), 32'd0);
      chk("rst_bus_valid", 32'(o_bv), 32'd0);
      chk("rst_bus_be", 32'(o_be), 32'd0);
      chk("rst_resp_rdata", o_rd, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Signed byte load from the upper lane.
    mem[2] = 8'hAA; mem[3] = 8'h80;
    run_access(1'b0, 1'b0, 16'h0003, 2'd0, 1'b1, 32'h0, 0, 0);
    chk("t1_addr", 32'(g_ba[0]), 32'h0002);
    chk("t1_be", 32'(g_be[0]), 32'h2);
    chk("t1_rdata", g_rd, 32'h0000FF80);
    chk("t1_lat", 32'(g_lat), 32'd2);

    // Split half-word store.
    run_access(1'b0, 1'b1, 16'h0005, 2'd1, 1'b0, 32'h1234, 0, 0);
    chk("t2_addr0", 32'(g_ba[0]), 32'h0004);
    chk("t2_be0", 32'(g_be[0]), 32'h2);
    chk("t2_wd0", g_wd[0], 32'h3412);
    chk("t2_addr1", 32'(g_ba[1]), 32'h0006);
    chk("t2_be1", 32'(g_be[1]), 32'h1);
    chk("t2_wd1", g_wd[1], 32'h3412);
    chk("t2_lat", 32'(g_lat), 32'd3);

    // Split load wrapping the address space.
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h56; mem[0] = 8'h78; mem[1] = 8'h00;
    run_access(1'b0, 1'b0, 16'hFFFF, 2'd1, 1'b0, 32'h0, 0, 0);
    chk("t3_addr0", 32'(g_ba[0]), 32'hFFFE);
    chk("t3_addr1", 32'(g_ba[1]), 32'h0000);
    chk("t3_rdata", g_rd, 32'h00007856);

    // 4-byte bus, unsigned half load with three wait states.
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hEF; mem[3] = 8'hBE;
    run_access(1'b1, 1'b0, 16'h0002, 2'd1, 1'b0, 32'h0, 0, 3);
    chk("t4_be", 32'(g_be[0]), 32'hC);
    chk("t4_rdata", g_rd, 32'h0000BEEF);
    chk("t4_lat", 32'(g_lat), 32'd5);

    // Reset during the second half of a split store.
    sel = 1'b0; req_write = 1'b1; req_addr = 16'h0005; req_size = 2'd1;
    req_wdata = 32'h1234; req_valid = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; bus_ready = 1'b1;
    chk("rst_mid_first", 32'(o_bv), 32'd1);
    @(negedge clk);
    chk("rst_mid_second_be", 32'(o_be), 32'h1);
    reset = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus_valid", 32'(o_bv), 32'd0);
    chk("rst_mid_req_ready", 32'(o_rr), 32'd1);
    chk("rst_mid_resp", 32'(o_rsv), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_resp", 32'(o_rsv), 32'd0);
    chk("rst_after_bus", 32'(o_bv), 32'd0);

    // req_valid held high with aligned full-width loads.
    sel = 1'b0; req_write = 1'b0; req_addr = 16'h0010; req_size = 2'd1;
    req_signed = 1'b0; req_valid = 1'b1; bus_ready = 1'b1; acc = 0;
    #1;
    for (int c = 0; c < 9; c++) begin
      chk("b2b_req_ready", 32'(o_rr), 32'((c % 3) == 0));
      if (c % 3 == 1) chk("b2b_first", 32'(o_bv), 32'd1);
      if (c % 3 == 2) chk("b2b_done", 32'(o_rsv), 32'd1);
      if (o_rr && req_valid) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0; bus_ready = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    @(negedge clk);

    for (int k = 0; k < 40; k++)
      run_access(1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
                 1'($urandom), $urandom, (k < 10) ? 0 : 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
